crc_engine: RTL and testbench

- Parametrised serial CRC generator/checker for the USB transmit and receive paths.
- Accumulates a CRC over stuffed-out data bits one bit per strobe.
- On request, shifts the complemented remainder out MSB-first to the bit stuffer under a ready handshake.
- Continuously flags whether the running remainder equals the protocol residual, for receive-side checking.
- One instance with CRC_WIDTH=5 covers token packets; one with CRC_WIDTH=16 covers data packets.

---
 rtl/crc_engine.sv | 180 ++++++++++++++++++
 tb/tb_crc_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// crc_engine: serial USB CRC generator/checker.
// Folds one data bit per bit_valid into the remainder. On request it shifts
// the complemented remainder out MSB-first under a bit_ready handshake.
// It also flags when the remainder equals the protocol residual, which is
// how the receive side checks a packet.
module crc_engine #(
    parameter int unsigned           CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0]  POLY      = CRC_WIDTH'(16'h8005),
    parameter logic [CRC_WIDTH-1:0]  INIT      = '1,
    parameter logic [CRC_WIDTH-1:0]  RESIDUAL  = CRC_WIDTH'(16'h800D)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 send_req,
    input  logic                 bit_ready,
    output logic                 crc_out,
    output logic                 crc_out_valid,
    output logic                 crc_busy,
    output logic                 crc_done,
    output logic [CRC_WIDTH-1:0] crc_value,
    output logic                 crc_match
);

    localparam int unsigned MSB   = CRC_WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(CRC_WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CRC_WIDTH);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SEND  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CRC_WIDTH-1:0]   r_rem;
    logic [CRC_WIDTH-1:0]   w_rem_next;
    logic [CRC_WIDTH-1:0]   w_rem_step;
    logic [CRC_WIDTH-1:0]   w_rem_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       w_bit_cnt_next;
    logic                   w_fb;
    logic                   w_last_accept;

    // Serial CRC step and send-shift candidates for the remainder.
    always_comb begin
        w_fb        = bit_in ^ r_rem[MSB];
        w_rem_step  = {r_rem[MSB-1:0], 1'b0} ^ (w_fb ? POLY : '0);
        w_rem_shift = {r_rem[MSB-1:0], 1'b1};
    end

    // The accept that consumes the final CRC bit ends the field.
    always_comb begin
        w_last_accept = (r_state == ST_SEND) && bit_ready && (r_bit_cnt == LAST_BIT);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; clear overrides every transition.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (send_req && (r_bit_cnt == '0)) begin
                        w_next_state = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_last_accept) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_ACCUM;
                end
                default: begin
                    w_next_state = ST_ACCUM;
                end
            endcase
        end
    end

    // FSM output decode plus the live remainder views.
    always_comb begin
        crc_out_valid = 1'b0;
        crc_busy      = 1'b0;
        crc_done      = 1'b0;
        case (r_state)
            ST_SEND: begin
                crc_out_valid = 1'b1;
                crc_busy      = 1'b1;
            end
            ST_DONE: begin
                crc_done = 1'b1;
            end
            default: begin
                crc_out_valid = 1'b0;
            end
        endcase
        crc_out   = ~r_rem[MSB];
        crc_value = r_rem;
        crc_match = (r_rem == RESIDUAL);
    end

    // Remainder next value: accumulate in ACCUM, shift out in SEND, reload after DONE.
    always_comb begin
        w_rem_next = r_rem;
        if (clear) begin
            w_rem_next = INIT;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (bit_valid) begin
                        w_rem_next = w_rem_step;
                    end
                end
                ST_SEND: begin
                    if (bit_ready) begin
                        w_rem_next = w_rem_shift;
                    end
                end
                ST_DONE: begin
                    w_rem_next = INIT;
                end
                default: begin
                    w_rem_next = INIT;
                end
            endcase
        end
    end

    // Sent-bit counter next value; saturates at CRC_WIDTH instead of wrapping.
    always_comb begin
        w_bit_cnt_next = r_bit_cnt;
        if (clear) begin
            w_bit_cnt_next = '0;
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (bit_ready && (r_bit_cnt != FULL_CNT)) begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    w_bit_cnt_next = '0;
                end
                default: begin
                    w_bit_cnt_next = r_bit_cnt;
                end
            endcase
        end
    end

    // Remainder and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem     <= INIT;
            r_bit_cnt <= '0;
        end else begin
            r_rem     <= w_rem_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed checks of a CRC5 and a CRC16 crc_engine instance.
module tb_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        c5_clear, c5_bit_valid, c5_bit_in, c5_send_req, c5_bit_ready;
    logic        c5_crc_out, c5_crc_out_valid, c5_crc_busy, c5_crc_done, c5_crc_match;
    logic [4:0]  c5_crc_value;

    logic        c16_clear, c16_bit_valid, c16_bit_in, c16_send_req, c16_bit_ready;
    logic        c16_crc_out, c16_crc_out_valid, c16_crc_busy, c16_crc_done, c16_crc_match;
    logic [15:0] c16_crc_value;

    int checks = 0;
    int errors = 0;

    logic [7:0]  data_bytes [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [15:0] nostall_bits;

    crc_engine #(
        .CRC_WIDTH (5),
        .POLY      (5'b00101),
        .INIT      (5'b11111),
        .RESIDUAL  (5'b01100)
    ) u_crc5 (
        .clk           (clk),
        .reset         (reset),
        .clear         (c5_clear),
        .bit_valid     (c5_bit_valid),
        .bit_in        (c5_bit_in),
        .send_req      (c5_send_req),
        .bit_ready     (c5_bit_ready),
        .crc_out       (c5_crc_out),
        .crc_out_valid (c5_crc_out_valid),
        .crc_busy      (c5_crc_busy),
        .crc_done      (c5_crc_done),
        .crc_value     (c5_crc_value),
        .crc_match     (c5_crc_match)
    );

    crc_engine #(
        .CRC_WIDTH (16),
        .POLY      (16'h8005),
        .INIT      (16'hFFFF),
        .RESIDUAL  (16'h800D)
    ) u_crc16 (
        .clk           (clk),
        .reset         (reset),
        .clear         (c16_clear),
        .bit_valid     (c16_bit_valid),
        .bit_in        (c16_bit_in),
        .send_req      (c16_send_req),
        .bit_ready     (c16_bit_ready),
        .crc_out       (c16_crc_out),
        .crc_out_valid (c16_crc_out_valid),
        .crc_busy      (c16_crc_busy),
        .crc_done      (c16_crc_done),
        .crc_value     (c16_crc_value),
        .crc_match     (c16_crc_match)
    );

    // Reflected byte-wise CRC-16/USB register (poly A001) over data_bytes.
    function automatic logic [15:0] ref_crc16_reflected();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {8'h00, data_bytes[b]};
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15 - i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c5_clear = 0; c5_bit_valid = 0; c5_bit_in = 0; c5_send_req = 0; c5_bit_ready = 0;
        c16_clear = 0; c16_bit_valid = 0; c16_bit_in = 0; c16_send_req = 0; c16_bit_ready = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic feed_data16();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                c16_bit_valid = 1'b1;
                c16_bit_in    = data_bytes[b][j];
                tick();
            end
        end
        c16_bit_valid = 1'b0;
        c16_bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (c16_crc_value !== 16'hFFFF) begin errors++; $display("FAIL reset_value16: got %h expected ffff", c16_crc_value); end
        checks++; if (c16_crc_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid16: got %b expected 0", c16_crc_out_valid); end
        checks++; if (c16_crc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b expected 0", c16_crc_busy); end
        checks++; if (c16_crc_done !== 1'b0) begin errors++; $display("FAIL reset_done16: got %b expected 0", c16_crc_done); end
        checks++; if (c16_crc_out !== 1'b0) begin errors++; $display("FAIL reset_out16: got %b expected 0", c16_crc_out); end
        checks++; if (c16_crc_match !== 1'b0) begin errors++; $display("FAIL reset_match16: got %b expected 0", c16_crc_match); end
        checks++; if (c5_crc_value !== 5'b11111) begin errors++; $display("FAIL reset_value5: got %b expected 11111", c5_crc_value); end
        checks++; if (c5_crc_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid5: got %b expected 0", c5_crc_out_valid); end
    endtask

    task automatic test_crc5_single_bit();
        apply_reset();
        c5_bit_valid = 1'b1;
        c5_bit_in    = 1'b0;
        tick();
        c5_bit_valid = 1'b0;
        checks++; if (c5_crc_value !== 5'b11011) begin errors++; $display("FAIL crc5_one_bit: got %b expected 11011", c5_crc_value); end
        checks++; if (c5_crc_match !== 1'b0) begin errors++; $display("FAIL crc5_one_bit_match: got %b expected 0", c5_crc_match); end
    endtask

    task automatic test_empty_send16();
        int  nvalid = 0;
        int  ndone  = 0;
        int  last_valid = -1;
        int  done_at = -1;
        apply_reset();
        c16_send_req  = 1'b1;
        c16_bit_ready = 1'b1;
        tick();
        c16_send_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (c16_crc_out_valid === 1'b1) begin
                nvalid++;
                last_valid = k;
                checks++; if (c16_crc_out !== 1'b0) begin errors++; $display("FAIL empty_send_bit%0d: got %b expected 0", k, c16_crc_out); end
            end
            if (c16_crc_done === 1'b1) begin
                ndone++;
                done_at = k;
            end
            tick();
        end
        c16_bit_ready = 1'b0;
        checks++; if (nvalid != 16) begin errors++; $display("FAIL empty_send_len: got %0d expected 16", nvalid); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL empty_send_done_count: got %0d expected 1", ndone); end
        checks++; if (done_at != last_valid + 1) begin errors++; $display("FAIL empty_send_done_time: got %0d expected %0d", done_at, last_valid + 1); end
        checks++; if (c16_crc_value !== 16'hFFFF) begin errors++; $display("FAIL empty_send_reload: got %h expected ffff", c16_crc_value); end
    endtask

    task automatic test_data_roundtrip16();
        logic [15:0] exp_c;
        logic [15:0] got;
        int          n = 0;
        logic        seen_done = 1'b0;
        exp_c = ref_crc16_reflected();
        got   = '0;
        apply_reset();
        feed_data16();
        checks++; if (c16_crc_value !== bitrev16(exp_c)) begin errors++; $display("FAIL data_remainder: got %h expected %h", c16_crc_value, bitrev16(exp_c)); end
        c16_send_req  = 1'b1;
        c16_bit_ready = 1'b1;
        tick();
        c16_send_req = 1'b0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (c16_crc_out_valid === 1'b1 && n < 16) begin
                got[n] = c16_crc_out;
                n++;
            end
            if (c16_crc_done === 1'b1) seen_done = 1'b1;
            tick();
        end
        c16_bit_ready = 1'b0;
        nostall_bits = got;
        checks++; if (!seen_done) begin errors++; $display("FAIL data_send_done: got none expected pulse"); end
        checks++; if (n != 16) begin errors++; $display("FAIL data_send_len: got %0d expected 16", n); end
        checks++; if (got !== ~exp_c) begin errors++; $display("FAIL data_send_bits: got %h expected %h", got, ~exp_c); end
        feed_data16();
        for (int i = 0; i < 16; i++) begin
            c16_bit_valid = 1'b1;
            c16_bit_in    = got[i];
            tick();
        end
        c16_bit_valid = 1'b0;
        checks++; if (c16_crc_match !== 1'b1) begin errors++; $display("FAIL residual_match: got %b expected 1", c16_crc_match); end
        checks++; if (c16_crc_value !== 16'h800D) begin errors++; $display("FAIL residual_value: got %h expected 800d", c16_crc_value); end
    endtask

    task automatic test_stall16();
        logic [15:0] got;
        logic [15:0] held_val;
        logic        held_out;
        logic        stalled_prev = 1'b0;
        logic        finished = 1'b0;
        int          acc = 0;
        int          last_acc = -1;
        got = '0; held_val = '0; held_out = 1'b0;
        apply_reset();
        feed_data16();
        c16_send_req = 1'b1;
        tick();
        c16_send_req = 1'b0;
        for (int k = 0; k < 80 && !finished; k++) begin
            if (c16_crc_done === 1'b1) begin
                finished = 1'b1;
                checks++; if (last_acc != k - 1) begin errors++; $display("FAIL stall_done_time: got %0d expected %0d", k, last_acc + 1); end
            end else if (c16_crc_out_valid === 1'b1) begin
                if (stalled_prev) begin
                    checks++; if (c16_crc_out !== held_out) begin errors++; $display("FAIL stall_hold_out%0d: got %b expected %b", k, c16_crc_out, held_out); end
                    checks++; if (c16_crc_value !== held_val) begin errors++; $display("FAIL stall_hold_value%0d: got %h expected %h", k, c16_crc_value, held_val); end
                end
                c16_bit_ready = ((k % 3) == 0);
                if (c16_bit_ready && acc < 16) begin
                    got[acc] = c16_crc_out;
                    acc++;
                    last_acc = k;
                end
                held_out     = c16_crc_out;
                held_val     = c16_crc_value;
                stalled_prev = !c16_bit_ready;
            end
            tick();
        end
        c16_bit_ready = 1'b0;
        checks++; if (!finished) begin errors++; $display("FAIL stall_done: got none expected pulse"); end
        checks++; if (acc != 16) begin errors++; $display("FAIL stall_accepts: got %0d expected 16", acc); end
        checks++; if (got !== nostall_bits) begin errors++; $display("FAIL stall_bits: got %h expected %h", got, nostall_bits); end
    endtask

    task automatic test_crc5_same_cycle();
        logic [4:0] exp_rem [5] = '{5'b11011, 5'b10111, 5'b01111, 5'b11111, 5'b11111};
        logic       exp_out [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        c5_bit_valid = 1'b1;
        c5_bit_in    = 1'b0;
        c5_send_req  = 1'b1;
        tick();
        c5_send_req  = 1'b0;
        c5_bit_in    = 1'b1;
        c5_bit_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (c5_crc_out_valid !== 1'b1) begin errors++; $display("FAIL crc5_valid%0d: got %b expected 1", k, c5_crc_out_valid); end
            checks++; if (c5_crc_out !== exp_out[k]) begin errors++; $display("FAIL crc5_out%0d: got %b expected %b", k, c5_crc_out, exp_out[k]); end
            checks++; if (c5_crc_value !== exp_rem[k]) begin errors++; $display("FAIL crc5_value%0d: got %b expected %b", k, c5_crc_value, exp_rem[k]); end
            tick();
        end
        checks++; if (c5_crc_done !== 1'b1) begin errors++; $display("FAIL crc5_done: got %b expected 1", c5_crc_done); end
        checks++; if (c5_crc_out_valid !== 1'b0) begin errors++; $display("FAIL crc5_valid_after: got %b expected 0", c5_crc_out_valid); end
        tick();
        c5_bit_valid = 1'b0;
        c5_bit_ready = 1'b0;
        checks++; if (c5_crc_value !== 5'b11111) begin errors++; $display("FAIL crc5_done_drop: got %b expected 11111", c5_crc_value); end
        checks++; if (c5_crc_done !== 1'b0) begin errors++; $display("FAIL crc5_done_width: got %b expected 0", c5_crc_done); end
    endtask

    task automatic test_clear_mid_send16();
        int nvalid = 0;
        int ndone  = 0;
        apply_reset();
        for (int j = 0; j < 8; j++) begin
            c16_bit_valid = 1'b1;
            c16_bit_in    = 1'b0;
            tick();
        end
        c16_bit_valid = 1'b0;
        checks++; if (c16_crc_value !== 16'hFD02) begin errors++; $display("FAIL zero_byte_value: got %h expected fd02", c16_crc_value); end
        c16_send_req  = 1'b1;
        c16_bit_ready = 1'b1;
        tick();
        c16_send_req = 1'b0;
        tick();
        tick();
        tick();
        c16_clear = 1'b1;
        tick();
        c16_clear     = 1'b0;
        c16_bit_ready = 1'b0;
        checks++; if (c16_crc_out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", c16_crc_out_valid); end
        checks++; if (c16_crc_busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", c16_crc_busy); end
        checks++; if (c16_crc_value !== 16'hFFFF) begin errors++; $display("FAIL clear_value: got %h expected ffff", c16_crc_value); end
        for (int k = 0; k < 4; k++) begin
            if (c16_crc_done === 1'b1 || c16_crc_out_valid === 1'b1) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL clear_no_done: got %0d expected 0", ndone); end
        ndone = 0;
        c16_send_req  = 1'b1;
        c16_bit_ready = 1'b1;
        tick();
        c16_send_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (c16_crc_out_valid === 1'b1) nvalid++;
            if (c16_crc_done === 1'b1) ndone++;
            tick();
        end
        c16_bit_ready = 1'b0;
        checks++; if (nvalid != 16) begin errors++; $display("FAIL clear_resend_len: got %0d expected 16", nvalid); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL clear_resend_done: got %0d expected 1", ndone); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_crc5_single_bit();
        test_empty_send16();
        test_data_roundtrip16();
        test_stall16();
        test_crc5_same_cycle();
        test_clear_mid_send16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
